voice_mixer: RTL
================

// Module: voice_mixer
// PURPOSE
//  Downstream of the phase accumulator.
//  - Once per sample_tick_in, snapshots the 24 voice phases and gates.
//  - Walks the voices serially through a shared sine ROM.
//  - Sums the active voices and emits one saturated signed 16-bit sample.
//  - Output feeds the audio DAC/PWM stage.
// PARAMETERS
//  NUM_VOICES   24  voices, one per phase_value entry
//  LUT_ADDR_W   8   ROM address width; phase bits [31:32-LUT_ADDR_W] form the address
//  SAMPLE_W     16  signed ROM data and output width
//  GAIN_SHIFT   3   arithmetic right shift of the sum before saturation
//  LUT_LATENCY  2   sine_lut read latency (fixed; the ROM is registered)
// PORTS
//  clk_in           in   1            system clock
//  rst_in           in   1            async active-high reset
//  sample_tick_in   in   1            one-cycle pulse at sample rate; starts a frame
//  gate_in          in   NUM_VOICES   per-voice active flags
//  phase_value      in   32 x NUM_VOICES  per-voice phase, unpacked array
//  sample_out       out  SAMPLE_W     signed mixed sample; held until the next frame
//  sample_valid_out out  1            one-cycle strobe when sample_out updates
//  busy_out         out  1            high while a frame is in progress (state != IDLE)
//  overrun_out      out  1            sticky: a tick arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; sample_out=0, sample_valid_out=0, busy_out=0, overrun_out=0.
//   - Accumulator, voice index, snapshots and pipeline valids are all cleared.
//  FSM states: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
//   IDLE : if tick at cycle T, on that edge:
//          - snap_addr[i] <= phase_value[i][31:24], snap_gate <= gate_in;
//          - acc <= 0, idx <= 0, go to FETCH.
//   FETCH: cycles T+1..T+NUM_VOICES.
//          - Drives ROM address snap_addr[idx]; snap_gate[idx] goes down a LUT_LATENCY-deep shift.
//          - idx increments each cycle; after idx == NUM_VOICES-1, go to DRAIN.
//   DRAIN: LUT_LATENCY cycles.
//          - ROM data for voice k is valid at T+1+k+LUT_LATENCY.
//          - acc += gate ? data : 0 on each valid-data cycle.
//   DONE : one cycle (T+27).
//          - sample_out <= sat(acc >>> GAIN_SHIFT); sample_valid_out <= 1; go to IDLE.
//  Latency: tick at T -> sample_valid_out high only in cycle T+28
//   (NUM_VOICES + LUT_LATENCY + 2).
//  Frame spacing: a tick in cycle T+28 (already IDLE) is accepted. Minimum spacing is 28 cycles.
//  Tick while busy (FETCH/DRAIN/DONE):
//   - ignored; the frame in progress is unaffected;
//   - overrun_out <= 1 and stays 1.
//  Arithmetic:
//   - acc is signed, SAMPLE_W+$clog2(NUM_VOICES) = 21 bits, so it cannot overflow.
//   - The shift is arithmetic.
//   - Saturate to [-32768, +32767].
//  Snapshot isolation: changes to gate_in or phase_value after the tick edge do not affect the frame.
//  sample_out holds its value between strobes. Reset mid-frame drops the frame: no strobe.
// STRUCTURE
//  synth_pkg:
//   - NUM_VOICES, LUT_ADDR_W, SAMPLE_W constants;
//   - typedef sample_t (logic signed [SAMPLE_W-1:0]);
//   - typedef enum mix_state_t {IDLE, FETCH, DRAIN, DONE}.
//  Sub-module sine_lut:
//   - 2^LUT_ADDR_W x SAMPLE_W ROM with registered address and registered data (2-cycle);
//   - entry i = round(32767*sin(2*pi*i/256)).
//  voice_mixer instantiates one sine_lut. All other logic is inline.
// TESTING
//  1. Reset -> all outputs 0. All gates 0, tick -> cycle T+28: sample_valid_out=1, sample_out=0;
//     strobe lasts exactly 1 cycle.
//  2. gate_in[5]=1, phase_value[5]=32'h4000_0000, tick -> sample_out=32767>>>3=4095.
//     Repeat with 32'hC000_0000 -> -4096.
//  3. All 24 gates, all phases 32'h4000_0000 -> sum 786408>>>3=98301 -> saturate to 32767.
//     All phases 32'hC000_0000 -> -32768.
//  4. Voices 0 and 23 at 0x40xx_xxxx, gates 0 and 23 set. Change gate_in/phase_value at T+1
//     -> sample_out=8191 (snapshot honoured).
//  5. Tick at T, extra tick at T+10 -> one strobe at T+28 with the correct value,
//     overrun_out=1 from T+11 onward. Tick at T+28 is accepted (strobe at T+56).
//  6. Assert rst_in asynchronously at T+12 mid-frame -> outputs 0 immediately, no strobe.
//     A new tick after release produces a normal frame.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants, types and the output saturation helper for the voice mixer.
package synth_pkg;

  localparam int NUM_VOICES  = 24;
  localparam int LUT_ADDR_W  = 8;
  localparam int SAMPLE_W    = 16;
  localparam int GAIN_SHIFT  = 3;
  localparam int LUT_LATENCY = 2;
  localparam int ACC_W       = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int IDX_W       = $clog2(NUM_VOICES);
  localparam int SAMPLE_MAX  = (2 ** (SAMPLE_W - 1)) - 1;
  localparam int SAMPLE_MIN  = -(2 ** (SAMPLE_W - 1));

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} mix_state_t;

  // Attenuate the voice sum, then clamp into the signed output range.
  function automatic sample_t sat_sample(input acc_t v);
    acc_t s;
    s = v >>> GAIN_SHIFT;
    if (s > acc_t'(SAMPLE_MAX))
      return sample_t'(SAMPLE_MAX);
    else if (s < acc_t'(SAMPLE_MIN))
      return sample_t'(SAMPLE_MIN);
    else
      return sample_t'(s);
  endfunction

endpackage

// File: rtl/sine_lut.sv
// 256-entry signed sine ROM, registered address and registered data (2-cycle read).
// Only the first quarter wave is stored; the other quadrants come from mirror and negate.
module sine_lut
  import synth_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [LUT_ADDR_W-1:0] addr_in,
  output sample_t               data_out
);

  // round(32767*sin(2*pi*k/256)) for k = 0..64
  localparam int unsigned QW [0:64] = '{
        0,   804,  1608,  2410,  3212,  4011,  4808,  5602,
     6393,  7179,  7962,  8739,  9512, 10278, 11039, 11793,
    12539, 13279, 14010, 14732, 15446, 16151, 16846, 17530,
    18204, 18868, 19519, 20159, 20787, 21403, 22005, 22594,
    23170, 23731, 24279, 24811, 25329, 25832, 26319, 26790,
    27245, 27683, 28105, 28510, 28898, 29268, 29621, 29956,
    30273, 30571, 30852, 31113, 31356, 31580, 31785, 31971,
    32137, 32285, 32412, 32521, 32609, 32678, 32728, 32757,
    32767
  };

  logic [LUT_ADDR_W-1:0] r_addr;
  sample_t               r_data;
  logic [5:0]            w_pos;
  logic [6:0]            w_qidx;
  sample_t               w_mag;
  sample_t               w_dat;

  always_comb begin
    w_pos  = r_addr[5:0];
    w_qidx = r_addr[6] ? 7'(64 - int'(w_pos)) : {1'b0, w_pos};
    w_mag  = sample_t'(QW[w_qidx]);
    w_dat  = r_addr[7] ? -w_mag : w_mag;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_addr <= addr_in;
      r_data <= w_dat;
    end
  end

  assign data_out = r_data;

endmodule

// File: rtl/voice_mixer.sv
// Per sample tick: snapshot all voice phases/gates, walk them through a shared sine ROM,
// sum the gated voices and emit one saturated sample with a single-cycle strobe.
module voice_mixer
  import synth_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sample_tick_in,
  input  logic [NUM_VOICES-1:0] gate_in,
  input  logic [31:0]           phase_value [NUM_VOICES],
  output sample_t               sample_out,
  output logic                  sample_valid_out,
  output logic                  busy_out,
  output logic                  overrun_out
);

  mix_state_t             r_state;
  mix_state_t             w_next_state;
  logic [LUT_ADDR_W-1:0]  r_snap_addr [NUM_VOICES];
  logic [NUM_VOICES-1:0]  r_snap_gate;
  logic [IDX_W-1:0]       r_idx;
  acc_t                   r_acc;
  logic [LUT_LATENCY-1:0] r_pipe_vld;
  logic [LUT_LATENCY-1:0] r_pipe_gate;
  sample_t                r_sample;
  logic                   r_sample_vld;
  logic                   r_overrun;

  logic                   w_busy;
  logic                   w_accept;
  logic                   w_fetching;
  logic                   w_draining;
  logic                   w_done;
  logic                   w_fetch_last;
  logic                   w_drain_last;
  logic [LUT_ADDR_W-1:0]  w_rom_addr;
  sample_t                w_rom_dat;

  sine_lut u_sine_lut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .addr_in  (w_rom_addr),
    .data_out (w_rom_dat)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (sample_tick_in) w_next_state = FETCH;
      FETCH:   if (w_fetch_last)   w_next_state = DRAIN;
      DRAIN:   if (w_drain_last)   w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != IDLE);
    w_accept     = (r_state == IDLE) && sample_tick_in;
    w_fetching   = (r_state == FETCH);
    w_draining   = (r_state == DRAIN);
    w_done       = (r_state == DONE);
    w_fetch_last = w_fetching && (r_idx == IDX_W'(NUM_VOICES - 1));
    w_drain_last = w_draining && (r_idx == IDX_W'(LUT_LATENCY - 1));
    w_rom_addr   = r_snap_addr[r_idx];
  end

  // The gate travels beside the ROM read so it lines up with that voice's data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_VOICES; i++) r_snap_addr[i] <= '0;
      r_snap_gate  <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_pipe_vld   <= '0;
      r_pipe_gate  <= '0;
      r_sample     <= '0;
      r_sample_vld <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_pipe_vld   <= {r_pipe_vld[LUT_LATENCY-2:0], w_fetching};
      r_pipe_gate  <= {r_pipe_gate[LUT_LATENCY-2:0], w_fetching & r_snap_gate[r_idx]};
      r_sample_vld <= w_done;
      if (w_busy && sample_tick_in)
        r_overrun <= 1'b1;
      if (w_done)
        r_sample <= sat_sample(r_acc);
      if (w_accept) begin
        for (int i = 0; i < NUM_VOICES; i++)
          r_snap_addr[i] <= phase_value[i][31 -: LUT_ADDR_W];
        r_snap_gate <= gate_in;
        r_acc       <= '0;
        r_idx       <= '0;
      end else begin
        if (r_pipe_vld[LUT_LATENCY-1] && r_pipe_gate[LUT_LATENCY-1])
          r_acc <= r_acc + {{(ACC_W - SAMPLE_W){w_rom_dat[SAMPLE_W-1]}}, w_rom_dat};
        if (w_fetch_last || w_drain_last)
          r_idx <= '0;
        else if (w_fetching || w_draining)
          r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign sample_out       = r_sample;
  assign sample_valid_out = r_sample_vld;
  assign busy_out         = w_busy;
  assign overrun_out      = r_overrun;

endmodule
